// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the reserve handshake.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;

  modport master (
    output ra, we, wa, wd, rsv_valid, rsv_addr,
    input  rd, rbusy, rsv_ok
  );

  modport slave (
    input  ra, we, wa, wd, rsv_valid, rsv_addr,
    output rd, rbusy, rsv_ok
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] sb_r;

  logic [AW-1:0]    ra_s   [NRD];
  logic [AW-1:0]    wa_s   [NWR];
  logic [XLEN-1:0]  wd_s   [NWR];
  logic [NREGS-1:0] wen_s;
  logic [XLEN-1:0]  wdat_s [NREGS];
  logic [NREGS-1:0] sb_nxt_s;
  logic [NREGS-1:0] set_s;
  logic             busy_s;
  logic             rsv_ok_s;
  logic [NRD*XLEN-1:0] rd_s;
  logic [NRD-1:0]      rbusy_s;

  // Unpack the flat port buses
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra_s[i] = bus.ra[i*AW +: AW];
    end
    for (int j = 0; j < NWR; j++) begin
      wa_s[j] = bus.wa[j*AW +: AW];
      wd_s[j] = bus.wd[j*XLEN +: XLEN];
    end
  end

  // Resolve write ports per register; later (higher) ports overwrite lower ones
  always_comb begin
    wen_s = '0;
    for (int k = 0; k < NREGS; k++) begin
      wdat_s[k] = '0;
    end
    for (int j = 0; j < NWR; j++) begin
      if (bus.we[j] && (wa_s[j] != '0)) begin
        wen_s[wa_s[j]]  = 1'b1;
        wdat_s[wa_s[j]] = wd_s[j];
      end else begin
        wen_s = wen_s;
      end
    end
  end

  // Reserve acceptance and next scoreboard state (release first, then reserve)
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    busy_s = sb_r[bus.rsv_addr] & ~wen_s[bus.rsv_addr];
`else
    busy_s = sb_r[bus.rsv_addr];
`endif
    rsv_ok_s = reset & bus.rsv_valid & ((bus.rsv_addr == '0) | ~busy_s);
    set_s    = (rsv_ok_s && (bus.rsv_addr != '0))
             ? ({{(NREGS-1){1'b0}}, 1'b1} << bus.rsv_addr) : '0;
    sb_nxt_s = (sb_r & ~wen_s) | set_s;
  end

  // Combinational read ports, forced to zero while reset is held
  always_comb begin
    rd_s    = '0;
    rbusy_s = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [XLEN-1:0] val_v;
      logic            bsy_v;
      val_v = (ra_s[i] == '0) ? '0 : regs_r[ra_s[i]];
      bsy_v = sb_r[ra_s[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        val_v = (bus.we[j] && (wa_s[j] == ra_s[i]) && (ra_s[i] != '0)) ? wd_s[j] : val_v;
        bsy_v = (bus.we[j] && (wa_s[j] == ra_s[i]) && (ra_s[i] != '0)) ? 1'b0 : bsy_v;
      end
`endif
      rd_s[i*XLEN +: XLEN] = reset ? val_v : '0;
      rbusy_s[i]           = reset & bsy_v;
    end
  end

  assign bus.rd     = rd_s;
  assign bus.rbusy  = rbusy_s;
  assign bus.rsv_ok = rsv_ok_s;

  // Register array and scoreboard; x0 is never enabled so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_r[k] <= '0;
      end
      sb_r <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (wen_s[k]) begin
          regs_r[k] <= wdat_s[k];
        end else begin
          regs_r[k] <= regs_r[k];
        end
      end
      sb_r <= sb_nxt_s;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (2 read / 2 write ports, 32x32).
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   applied;
  int   errs;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        rv;
    logic [4:0]  raddr;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic        e_ok;
  } vec_t;

  vec_t tv [18];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic rv, logic [4:0] raddr,
                              logic [31:0] e_rd0, logic [31:0] e_rd1,
                              logic [1:0] e_busy, logic e_ok);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.rv = rv; v.raddr = raddr;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy = e_busy; v.e_ok = e_ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.we        = v.we;
    bus.wa        = {v.wa1, v.wa0};
    bus.wd        = {v.wd1, v.wd0};
    bus.ra        = {v.ra1, v.ra0};
    bus.rsv_valid = v.rv;
    bus.rsv_addr  = v.raddr;
  endtask

  initial begin
    applied = 0;
    errs    = 0;

    //            we     wa0    wd0            wa1    wd1            ra0    ra1    rv    raddr  e_rd0                         e_rd1                        e_busy                    e_ok
    tv[0]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd0,  32'h0,                        32'h0,                       2'b00,                    1'b0);
    tv[1]  = mk(2'b10, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  1'b1, 5'd0,  32'h0,                        32'h0,                       2'b00,                    1'b1);
    tv[2]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd0,  32'h0,                        32'h0,                       2'b00,                    1'b0);
    tv[3]  = mk(2'b11, 5'd5,  32'h1111_1111, 5'd5,  32'h2222_2222, 5'd5,  5'd0,  1'b0, 5'd0,  BYP ? 32'h2222_2222 : 32'h0,  32'h0,                       2'b00,                    1'b0);
    tv[4]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd5,  1'b0, 5'd0,  32'h2222_2222,                32'h2222_2222,               2'b00,                    1'b0);
    tv[5]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0,  1'b1, 5'd7,  32'h0,                        32'h0,                       2'b00,                    1'b1);
    tv[6]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0,  1'b1, 5'd7,  32'h0,                        32'h0,                       2'b01,                    1'b0);
    tv[7]  = mk(2'b01, 5'd7,  32'h0000_0042, 5'd0,  32'h0,         5'd7,  5'd0,  1'b0, 5'd0,  BYP ? 32'h42 : 32'h0,         32'h0,                       BYP ? 2'b00 : 2'b01,      1'b0);
    tv[8]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0,  1'b0, 5'd0,  32'h0000_0042,                32'h0,                       2'b00,                    1'b0);
    tv[9]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd9,  1'b1, 5'd9,  32'h0,                        32'h0,                       2'b00,                    1'b1);
    tv[10] = mk(2'b10, 5'd0,  32'h0,         5'd9,  32'h0000_0001, 5'd0,  5'd9,  1'b1, 5'd9,  32'h0,                        BYP ? 32'h1 : 32'h0,         BYP ? 2'b00 : 2'b10,      BYP);
    tv[11] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd9,  1'b0, 5'd0,  32'h0,                        32'h0000_0001,               BYP ? 2'b10 : 2'b00,      1'b0);
    tv[12] = mk(2'b01, 5'd3,  32'h0000_0033, 5'd0,  32'h0,         5'd3,  5'd0,  1'b0, 5'd0,  BYP ? 32'h33 : 32'h0,         32'h0,                       2'b00,                    1'b0);
    tv[13] = mk(2'b10, 5'd0,  32'h0,         5'd12, 32'hDEAD_BEEF, 5'd12, 5'd3,  1'b0, 5'd0,  BYP ? 32'hDEAD_BEEF : 32'h0,  32'h0000_0033,               2'b00,                    1'b0);
    tv[14] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd12, 5'd0,  1'b1, 5'd14, 32'hDEAD_BEEF,                32'h0,                       2'b00,                    1'b1);
    tv[15] = mk(2'b11, 5'd14, 32'h0000_000A, 5'd14, 32'h0000_000B, 5'd12, 5'd14, 1'b0, 5'd0,  32'hDEAD_BEEF,                BYP ? 32'hB : 32'h0,         BYP ? 2'b00 : 2'b10,      1'b0);
    tv[16] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd14, 5'd14, 1'b1, 5'd14, 32'h0000_000B,                32'h0000_000B,               2'b00,                    1'b1);
    tv[17] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd14, 5'd0,  1'b1, 5'd14, 32'h0000_000B,                32'h0,                       2'b01,                    1'b0);

    // Reset held with writes pending: outputs stay zero, nothing lands
    reset         = 1'b0;
    bus.we        = 2'b11;
    bus.wa        = {5'd4, 5'd3};
    bus.wd        = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    bus.ra        = {5'd4, 5'd3};
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_rd0_c%0d", c), bus.rd[31:0], 32'h0);
      chk($sformatf("rst_rd1_c%0d", c), bus.rd[63:32], 32'h0);
      chk($sformatf("rst_ok_c%0d", c), {31'h0, bus.rsv_ok}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_rd0_pre_edge", bus.rd[31:0], BYP ? 32'hAAAA_AAAA : 32'h0);
    chk("rel_ok_pre_edge", {31'h0, bus.rsv_ok}, 32'h1);
    @(posedge clk);
    #1;
    bus.we        = 2'b00;
    bus.rsv_valid = 1'b0;
    chk("rel_rd0_post_edge", bus.rd[31:0], 32'hAAAA_AAAA);
    chk("rel_rd1_post_edge", bus.rd[63:32], 32'hBBBB_BBBB);
    bus.ra = {5'd6, 5'd3};
    #1;
    chk("rel_busy6", {31'h0, bus.rbusy[1]}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_rd0", bus.rd[31:0], 32'h0);
    chk("async_rst_busy", {30'h0, bus.rbusy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("after_rst_reg3", bus.rd[31:0], 32'h0);
    chk("after_rst_busy6", {31'h0, bus.rbusy[1]}, 32'h0);

    // Directed vector table: drive on falling edge, compare combinational outputs
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_rd0", i), bus.rd[31:0], tv[i].e_rd0);
      chk($sformatf("v%0d_rd1", i), bus.rd[63:32], tv[i].e_rd1);
      chk($sformatf("v%0d_rbusy", i), {30'h0, bus.rbusy}, {30'h0, tv[i].e_busy});
      chk($sformatf("v%0d_rsv_ok", i), {31'h0, bus.rsv_ok}, {31'h0, tv[i].e_ok});
    end

    @(negedge clk);
    bus.we        = 2'b00;
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined RISC-V core. It replaces the fixed 2-read/1-write file. The block has NRD combinational read ports, NWR synchronous write ports with defined collision priority, and a per-register busy scoreboard. Decode uses the scoreboard to stall on RAW hazards from multi-cycle units. Sits between decode (reads, reserve) and writeback (writes, release).

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of 2, >=2); AW = log2(NREGS)
NRD, 2, number of read ports (1..4)
NWR, 2, number of write ports (1..3)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
ra  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  output  NRD  port i source register has a pending producer
we  input  NWR  write enable per write port
wa  input  NWR*AW  write addresses
wd  input  NWR*XLEN  write data
rsv_valid  input  1  reserve request from issue
rsv_addr  input  AW  destination register being reserved
rsv_ok  output  1  reservation accepted this cycle

Behaviour:
- Storage: NREGS x XLEN array plus NREGS-bit scoreboard sb. Register 0 is constant zero. Writes to 0 are ignored. sb[0] is never set.
- Reset (reset=0, asynchronous): every register is cleared to 0 and sb is cleared to 0. While reset is low, rd is all 0, rbusy is 0 and rsv_ok is 0. The first writes take effect on the first rising clk after reset deasserts.
- Read: combinational, zero latency.
  - rd[i] = 0 when ra[i]==0, else reg[ra[i]].
  - rbusy[i] = sb[ra[i]].
- Write: registered, visible on read ports the cycle after the edge.
  - Each port j with we[j]=1 and wa[j]!=0 writes wd[j].
  - Same-address collision: the highest-index port wins. Lower ports on that address are dropped silently.
- Scoreboard release: any accepted write (we[j]=1, wa[j]!=0) clears sb[wa[j]] at the edge.
- Scoreboard reserve:
  - rsv_ok = rsv_valid & (rsv_addr==0 | ~sb[rsv_addr]) & reset. This is combinational.
  - When rsv_ok=1 and rsv_addr!=0, sb[rsv_addr] is set at the edge.
  - Reserving an already-busy register is refused with rsv_ok=0 and no state change. Issue must stall (WAW).
  - Reserving 0 is accepted with no state change.
- Simultaneous release and reserve on the same address in the same cycle:
  - The register must have been busy, so the reserve is refused (rsv_ok=0).
  - sb clears. The write lands.
- Release with no reservation is legal. The write lands and sb stays 0.
- Multiple ports releasing the same address behave as a single release.
- No internal FSM beyond the sb bits. All next-state logic is a single always_ff with async reset.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If any port j has we[j]=1, wa[j]==ra[i] and ra[i]!=0, rd[i] = wd[j] in the same cycle. The highest-index matching j wins.
  - rbusy[i] is also forced to 0 in that case.
  - rsv_ok treats an in-flight same-cycle release as clearing the busy bit. Reserving that address is accepted, and sb ends set: the reserve overrides the release.
- Undefined: reads return stored values only. Same-cycle writes become visible next cycle. Release/reserve collision follows the Behaviour rule above.

Test Plan:
1. Reset with writes pending: drive we=2'b11, wa=3/4, wd=AAAA_AAAA/BBBB_BBBB with reset=0 for 3 cycles, release reset mid-cycle -> ra=3,4 read 0 throughout reset; read AAAA_AAAA/BBBB_BBBB only after first post-release edge; reset asserted again mid-test clears immediately (asynchronously).
2. x0 protection: write port1 wa=0, wd=FFFF_FFFF; reserve rsv_addr=0 -> rd for ra=0 stays 0, rsv_ok=1, rbusy for ra=0 stays 0.
3. Collision: port0 and port1 both write reg 5 with 1111_1111 and 2222_2222 -> next cycle ra=5 reads 2222_2222.
4. Scoreboard lifecycle:
   - Reserve reg 7 -> rsv_ok=1; next cycle rbusy=1 for ra=7.
   - Second reserve of 7 -> rsv_ok=0.
   - Write 7 = 0000_0042 -> next cycle rbusy=0 and rd=0000_0042.
5. Same-cycle release+reserve of reg 9 (sb[9]=1), write 9 = 0000_0001:
   - Without REGFILE_BYPASS_EN: rsv_ok=0; sb[9]=0 after the edge.
   - With REGFILE_BYPASS_EN: rsv_ok=1; sb[9]=1 after the edge; rd[ra=9] shows 0000_0001 that cycle.
6. Bypass: with REGFILE_BYPASS_EN, write reg 12 = DEAD_BEEF while ra=12 -> rd=DEAD_BEEF in the same cycle. Without the macro -> old value that cycle, DEAD_BEEF the next cycle.
